// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver feeding the receive data register.
// Each bit is decided by a 3-sample majority vote around mid-bit. Glitch
// start bits are rejected. A low stop bit raises a one-cycle framing error.
//
// Ports:
//   PCLK         system clock, rising edge
//   PRESET       synchronous active-high reset
//   i_rx_serial  asynchronous serial line, idle high
//   o_rx_dv      one-cycle pulse, o_rx_byte holds a new good frame
//   o_rx_byte    last good byte, held between frames
//   o_frame_err  one-cycle pulse, stop bit sampled low
//   o_busy       high whenever the receiver is not idle
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 i_rx_serial,
    output logic                 o_rx_dv,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_frame_err,
    output logic                 o_busy
);

    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int IW  = $clog2(DATA_BITS);
    localparam int MID = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MID_M1 = CW'(MID - 1);
    localparam logic [CW-1:0] CNT_MID    = CW'(MID);
    localparam logic [CW-1:0] CNT_MID_P1 = CW'(MID + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_ZERO   = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Majority of three samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    state_t               state, state_nx;
    logic                 sync1, rx_s;
    logic                 samp_a, samp_a_nx;
    logic                 samp_b, samp_b_nx;
    logic [CW-1:0]        clk_cnt, cnt_nx, cnt_inc;
    logic [IW-1:0]        bit_idx, idx_nx;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [DATA_BITS-1:0] byte_nx;
    logic                 dv_nx, fe_nx, busy_nx;
    logic                 at_last, vote;

    // Next-state and datapath decode.
    always_comb begin
        state_nx  = state;
        cnt_nx    = clk_cnt;
        idx_nx    = bit_idx;
        shift_nx  = shift;
        byte_nx   = o_rx_byte;
        dv_nx     = 1'b0;
        fe_nx     = 1'b0;
        samp_a_nx = samp_a;
        samp_b_nx = samp_b;

        at_last = (clk_cnt == CNT_LAST);
        cnt_inc = at_last ? CNT_ZERO : (clk_cnt + CNT_ONE);
        // Third sample is the live rx_s at MID+1; the other two are held.
        vote    = maj3(samp_a, samp_b, rx_s);

        if (state != IDLE && state != WAIT_HIGH) begin
            if (clk_cnt == CNT_MID_M1) begin
                samp_a_nx = rx_s;
            end else begin
                samp_a_nx = samp_a;
            end
            if (clk_cnt == CNT_MID) begin
                samp_b_nx = rx_s;
            end else begin
                samp_b_nx = samp_b;
            end
        end else begin
            samp_a_nx = samp_a;
            samp_b_nx = samp_b;
        end

        case (state)
            IDLE: begin
                cnt_nx = CNT_ZERO;
                idx_nx = IDX_ZERO;
                if (!rx_s) begin
                    state_nx = START;
                end else begin
                    state_nx = IDLE;
                end
            end
            START: begin
                cnt_nx = cnt_inc;
                if (clk_cnt == CNT_MID_P1 && vote) begin
                    // Line was back high at mid start bit: glitch, not a frame.
                    state_nx = IDLE;
                    cnt_nx   = CNT_ZERO;
                end else if (at_last) begin
                    state_nx = DATA;
                    idx_nx   = IDX_ZERO;
                end else begin
                    state_nx = START;
                end
            end
            DATA: begin
                cnt_nx = cnt_inc;
                if (clk_cnt == CNT_MID_P1) begin
                    // LSB first: shift right, newest bit enters at the MSB.
                    shift_nx = {vote, shift[DATA_BITS-1:1]};
                end else begin
                    shift_nx = shift;
                end
                if (at_last) begin
                    if (bit_idx == IDX_LAST) begin
                        state_nx = STOP;
                        idx_nx   = IDX_ZERO;
                    end else begin
                        idx_nx = bit_idx + IDX_ONE;
                    end
                end else begin
                    idx_nx = bit_idx;
                end
            end
            STOP: begin
                cnt_nx = cnt_inc;
                // Decide at mid stop bit so a following start edge is not missed.
                if (clk_cnt == CNT_MID_P1) begin
                    cnt_nx = CNT_ZERO;
                    if (vote) begin
                        dv_nx    = 1'b1;
                        byte_nx  = shift;
                        state_nx = IDLE;
                    end else begin
                        fe_nx    = 1'b1;
                        state_nx = WAIT_HIGH;
                    end
                end else begin
                    state_nx = STOP;
                end
            end
            WAIT_HIGH: begin
                // Stay here through a break so it yields only one error.
                cnt_nx = CNT_ZERO;
                if (rx_s) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = WAIT_HIGH;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = CNT_ZERO;
                idx_nx   = IDX_ZERO;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    // State, synchroniser, datapath and output registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
            clk_cnt     <= CNT_ZERO;
            bit_idx     <= IDX_ZERO;
            shift       <= {DATA_BITS{1'b0}};
            o_rx_dv     <= 1'b0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
            o_rx_byte   <= {DATA_BITS{1'b0}};
        end else begin
            state       <= state_nx;
            sync1       <= i_rx_serial;
            rx_s        <= sync1;
            samp_a      <= samp_a_nx;
            samp_b      <= samp_b_nx;
            clk_cnt     <= cnt_nx;
            bit_idx     <= idx_nx;
            shift       <= shift_nx;
            o_rx_dv     <= dv_nx;
            o_frame_err <= fe_nx;
            o_busy      <= busy_nx;
            o_rx_byte   <= byte_nx;
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os with CLKS_PER_BIT=16, DATA_BITS=8.
// The line is driven on falling clock edges. A frame whose start bit is
// driven just after rising edge t0 is first registered at edge k=t0+1, so
// the valid/error pulse is seen at the falling edge after edge t0+156
// (k+156 in cycle numbering where cycle n ends at edge n).
module tb_uart_rx_os;

    localparam int CPB = 16;
    localparam int NB  = 8;
    localparam int MID = (CPB - 1) / 2;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          i_rx_serial;
    logic          o_rx_dv;
    logic [NB-1:0] o_rx_byte;
    logic          o_frame_err;
    logic          o_busy;

    uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .i_rx_serial (i_rx_serial),
        .o_rx_dv     (o_rx_dv),
        .o_rx_byte   (o_rx_byte),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    int           dv_cyc[$];
    logic [7:0]   dv_byte[$];
    int           fe_cyc[$];
    int           busy_rise = -1;
    int           busy_fall = -1;
    logic         busy_q    = 1'b0;

    // Record output events, sampled on the falling edge.
    always @(negedge PCLK) begin
        if (o_rx_dv) begin
            dv_cyc.push_back(cyc);
            dv_byte.push_back(o_rx_byte);
        end
        if (o_frame_err) fe_cyc.push_back(cyc);
        if (o_busy && !busy_q) busy_rise = cyc;
        if (!o_busy && busy_q) busy_fall = cyc;
        busy_q = o_busy;
        if (o_rx_dv || o_frame_err) begin
            n_checks++;
            assert (!(o_rx_dv && o_frame_err)) else begin
                n_fail++;
                $error("FAIL pulse_exclusive: observed dv=%0b fe=%0b, expected not both", o_rx_dv, o_frame_err);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        dv_cyc.delete();
        dv_byte.delete();
        fe_cyc.delete();
        busy_rise = -1;
        busy_fall = -1;
    endtask

    task automatic idle_bits(input int n);
        i_rx_serial = 1'b1;
        repeat (n * CPB) @(negedge PCLK);
    endtask

    // Drive one 10-bit frame. noise inverts the line for one cycle so that
    // the receiver sees it at clk_cnt=MID of every data bit. rst_bit>=0
    // pulses PRESET for one cycle in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input bit noise, input int rst_bit, output int t0);
        logic val;
        t0 = cyc;
        for (int b = 0; b < 10; b++) begin
            if (b == 0)      val = 1'b0;
            else if (b == 9) val = stop_val;
            else             val = d[b-1];
            for (int j = 0; j < CPB; j++) begin
                if (rst_bit >= 0 && b == rst_bit + 1 && j == 9) begin
                    check("rst_busy", {31'd0, o_busy}, 32'd0);
                    check("rst_byte", {24'd0, o_rx_byte}, 32'd0);
                end
                i_rx_serial = (noise && b >= 1 && b <= 8 && j == MID + 1) ? ~val : val;
                PRESET      = (rst_bit >= 0 && b == rst_bit + 1 && j == 8);
                @(negedge PCLK);
            end
        end
        PRESET = 1'b0;
    endtask

    int t0, ta, tb, tc;

    initial begin
        // Reset state
        PRESET      = 1'b1;
        i_rx_serial = 1'b1;
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        check("reset_dv",   {31'd0, o_rx_dv},     32'd0);
        check("reset_fe",   {31'd0, o_frame_err}, 32'd0);
        check("reset_busy", {31'd0, o_busy},      32'd0);
        check("reset_byte", {24'd0, o_rx_byte},   32'd0);
        idle_bits(2);

        // Single good frame 0xA5
        clear_log();
        send_frame(8'hA5, 1'b1, 1'b0, -1, t0);
        idle_bits(2);
        check("a5_count",     dv_cyc.size(), 32'd1);
        check("a5_time",      dv_cyc[0],     t0 + 156);
        check("a5_byte",      {24'd0, dv_byte[0]}, 32'hA5);
        check("a5_fe",        fe_cyc.size(), 32'd0);
        check("a5_busy_rise", busy_rise,     t0 + 3);
        check("a5_busy_fall", busy_fall,     t0 + 156);
        check("a5_hold",      {24'd0, o_rx_byte}, 32'hA5);

        // Back-to-back 0x00, 0xFF, 0x3C with no idle gap
        clear_log();
        send_frame(8'h00, 1'b1, 1'b0, -1, ta);
        send_frame(8'hFF, 1'b1, 1'b0, -1, tb);
        send_frame(8'h3C, 1'b1, 1'b0, -1, tc);
        idle_bits(2);
        check("b2b_count", dv_cyc.size(), 32'd3);
        check("b2b_time0", dv_cyc[0], ta + 156);
        check("b2b_gap1",  dv_cyc[1] - dv_cyc[0], 32'd160);
        check("b2b_gap2",  dv_cyc[2] - dv_cyc[1], 32'd160);
        check("b2b_byte0", {24'd0, dv_byte[0]}, 32'h00);
        check("b2b_byte1", {24'd0, dv_byte[1]}, 32'hFF);
        check("b2b_byte2", {24'd0, dv_byte[2]}, 32'h3C);
        check("b2b_fe",    fe_cyc.size(), 32'd0);

        // Glitch start: 4 cycles low
        clear_log();
        i_rx_serial = 1'b0;
        repeat (4) @(negedge PCLK);
        idle_bits(2);
        check("glitch_dv",   dv_cyc.size(), 32'd0);
        check("glitch_fe",   fe_cyc.size(), 32'd0);
        check("glitch_busy", {31'd0, o_busy}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, -1, t0);
        idle_bits(1);
        check("glitch_next_count", dv_cyc.size(), 32'd1);
        check("glitch_next_byte",  {24'd0, dv_byte[0]}, 32'h5A);

        // Framing error followed by a 30-bit break
        clear_log();
        send_frame(8'h81, 1'b0, 1'b0, -1, t0);
        i_rx_serial = 1'b0;
        repeat (30 * CPB) @(negedge PCLK);
        check("brk_fe_count", fe_cyc.size(), 32'd1);
        check("brk_fe_time",  fe_cyc[0], t0 + 156);
        check("brk_dv",       dv_cyc.size(), 32'd0);
        check("brk_hold",     {24'd0, o_rx_byte}, 32'h5A);
        check("brk_busy",     {31'd0, o_busy}, 32'd1);
        idle_bits(2);
        check("brk_release_busy", {31'd0, o_busy}, 32'd0);
        send_frame(8'h42, 1'b1, 1'b0, -1, t0);
        idle_bits(1);
        check("brk_next_count", dv_cyc.size(), 32'd1);
        check("brk_next_byte",  {24'd0, dv_byte[0]}, 32'h42);
        check("brk_fe_total",   fe_cyc.size(), 32'd1);

        // Single-cycle noise at mid of every data bit
        clear_log();
        send_frame(8'hC3, 1'b1, 1'b1, -1, t0);
        idle_bits(1);
        check("noise_count", dv_cyc.size(), 32'd1);
        check("noise_byte",  {24'd0, dv_byte[0]}, 32'hC3);

        // Reset during data bit 3 (line high then and afterwards)
        clear_log();
        send_frame(8'hF8, 1'b1, 1'b0, 3, t0);
        idle_bits(2);
        check("rst_dv",        dv_cyc.size(), 32'd0);
        check("rst_fe",        fe_cyc.size(), 32'd0);
        check("rst_byte_hold", {24'd0, o_rx_byte}, 32'd0);
        send_frame(8'h99, 1'b1, 1'b0, -1, t0);
        idle_bits(1);
        check("rst_next_count", dv_cyc.size(), 32'd1);
        check("rst_next_time",  dv_cyc[0], t0 + 156);
        check("rst_next_byte",  {24'd0, dv_byte[0]}, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
